// File: rtl/aes_inv_key_expander.sv
// rtl/aes_inv_key_expander.sv - AES-128 backward key schedule from the round-10 key to round 0
// One round per clock; all 11 round keys are kept in a table read by round index.
module aes_inv_key_expander #(
  parameter int KEY_WIDTH  = 128,
  parameter int NUM_ROUNDS = 10
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start,
  input  logic [KEY_WIDTH-1:0] last_key,
  input  logic [3:0]           key_sel,
  output logic [KEY_WIDTH-1:0] round_key,
  output logic                 key_rdy,
  output logic                 busy,
  output logic                 gen_valid,
  output logic [KEY_WIDTH-1:0] gen_key,
  output logic [3:0]           gen_round
);

  localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS);

  // Forward S-box, row 0 in the most significant bits.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {S_IDLE, S_GEN, S_DONE} state_t;

  state_t         r_state, w_next;
  logic [3:0]     r_rnd;
  logic [127:0]   r_cur;
  logic [127:0]   r_table [0:NUM_ROUNDS];
  logic           r_key_rdy, r_busy, r_gen_valid;
  logic [127:0]   r_gen_key;
  logic [3:0]     r_gen_round;

  logic [31:0]    w_a0, w_a1, w_a2, w_a3, w_b0, w_b1, w_b2, w_b3, w_rot, w_sub;
  logic [127:0]   w_prev;
  logic [3:0]     w_rnd_m1;
  logic           w_load, w_step;

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [10:0] idx;
    idx = {~x, 3'b000};
    return SBOX[idx +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  assign {w_a0, w_a1, w_a2, w_a3} = r_cur;
  assign w_b3     = w_a3 ^ w_a2;
  assign w_b2     = w_a2 ^ w_a1;
  assign w_b1     = w_a1 ^ w_a0;
  assign w_rot    = {w_b3[23:0], w_b3[31:24]};
  assign w_sub    = {sbox(w_rot[31:24]), sbox(w_rot[23:16]), sbox(w_rot[15:8]), sbox(w_rot[7:0])};
  assign w_b0     = w_a0 ^ w_sub ^ {rcon(r_rnd), 24'h0};
  assign w_prev   = {w_b0, w_b1, w_b2, w_b3};
  assign w_rnd_m1 = r_rnd - 4'd1;

  // A start arriving mid-expansion is dropped so the table is never half overwritten.
  assign w_load = start && (r_state != S_GEN);
  assign w_step = (r_state == S_GEN);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (start) w_next = S_GEN;
      S_GEN:          if (r_rnd == 4'd1) w_next = S_DONE;
      default:        w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i <= NUM_ROUNDS; i++) r_table[i] <= '0;
      r_cur       <= '0;
      r_rnd       <= '0;
      r_key_rdy   <= 1'b0;
      r_busy      <= 1'b0;
      r_gen_valid <= 1'b0;
      r_gen_key   <= '0;
      r_gen_round <= '0;
    end else begin
      r_gen_valid <= 1'b0;
      if (w_load) begin
        r_table[LAST_RND] <= last_key;
        r_cur             <= last_key;
        r_rnd             <= LAST_RND;
        r_gen_valid       <= 1'b1;
        r_gen_key         <= last_key;
        r_gen_round       <= LAST_RND;
        r_key_rdy         <= 1'b0;
        r_busy            <= 1'b1;
      end else if (w_step) begin
        r_table[w_rnd_m1] <= w_prev;
        r_cur             <= w_prev;
        r_rnd             <= w_rnd_m1;
        r_gen_valid       <= 1'b1;
        r_gen_key         <= w_prev;
        r_gen_round       <= w_rnd_m1;
        if (r_rnd == 4'd1) begin
          r_key_rdy <= 1'b1;
          r_busy    <= 1'b0;
        end
      end
    end
  end

  assign round_key = (key_sel <= LAST_RND) ? r_table[key_sel] : '0;
  assign key_rdy   = r_key_rdy;
  assign busy      = r_busy;
  assign gen_valid = r_gen_valid;
  assign gen_key   = r_gen_key;
  assign gen_round = r_gen_round;

endmodule

// File: tb/tb_aes_inv_key_expander.sv
// tb/tb_aes_inv_key_expander.sv - bench for aes_inv_key_expander against a word-recurrence model
module tb_aes_inv_key_expander;

  logic         clk = 1'b0;
  logic         resetn, start;
  logic [127:0] last_key, round_key, gen_key;
  logic [3:0]   key_sel, gen_round;
  logic         key_rdy, busy, gen_valid;

  int           n_checks = 0;
  int           n_fail   = 0;
  logic [7:0]   sbox_m [256];
  logic [7:0]   rcon_m [11];
  logic [127:0] exp_keys [11];

  localparam logic [127:0] FIPS_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  aes_inv_key_expander dut (
    .clk(clk), .resetn(resetn), .start(start), .last_key(last_key), .key_sel(key_sel),
    .round_key(round_key), .key_rdy(key_rdy), .busy(busy), .gen_valid(gen_valid),
    .gen_key(gen_key), .gen_round(gen_round)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  // S-box from GF(2^8) inverse plus affine map, rcon by repeated doubling.
  task automatic build_tables();
    for (int a = 0; a < 256; a++) begin
      logic [7:0] inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sbox_m[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
    rcon_m[0] = 8'h00;
    rcon_m[1] = 8'h01;
    for (int i = 2; i <= 10; i++) rcon_m[i] = gmul(rcon_m[i-1], 8'h02);
  endtask

  // Invert w[i] = w[i-4] ^ f(w[i-1]) over the 44-word schedule.
  task automatic model(input logic [127:0] k10);
    logic [31:0] w [44];
    logic [31:0] t;
    for (int j = 0; j < 4; j++) w[40+j] = k10[127-32*j -: 32];
    for (int i = 43; i >= 4; i--) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
        t = t ^ {rcon_m[i/4], 24'h0};
      end
      w[i-4] = w[i] ^ t;
    end
    for (int r = 0; r <= 10; r++) exp_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic check_table();
    for (int s = 0; s < 16; s++) begin
      @(negedge clk);
      key_sel = 4'(s);
      #1;
      check("table_read", round_key, (s <= 10) ? exp_keys[s] : 128'h0);
    end
  endtask

  task automatic stream_check(input logic [127:0] k, input int glitch);
    model(k);
    @(negedge clk);
    last_key = k;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    for (int i = 10; i >= 0; i--) begin
      check("gen_valid", 128'(gen_valid), 128'h1);
      check("gen_round", 128'(gen_round), 128'(i));
      check("gen_key", gen_key, exp_keys[i]);
      check("busy_gen", 128'(busy), 128'(i > 0));
      check("key_rdy_gen", 128'(key_rdy), 128'(i == 0));
      if (i == glitch) begin
        start    = 1'b1;
        last_key = ~k;
      end else begin
        start    = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("gen_valid_end", 128'(gen_valid), 128'h0);
    check("key_rdy_end", 128'(key_rdy), 128'h1);
    check("busy_end", 128'(busy), 128'h0);
    check_table();
  endtask

  initial begin
    resetn   = 1'b0;
    start    = 1'b0;
    last_key = '0;
    key_sel  = 4'd10;
    build_tables();
    repeat (3) @(negedge clk);
    check("rst_key_rdy", 128'(key_rdy), 128'h0);
    check("rst_busy", 128'(busy), 128'h0);
    check("rst_gen_valid", 128'(gen_valid), 128'h0);
    check("rst_gen_key", gen_key, 128'h0);
    check("rst_gen_round", 128'(gen_round), 128'h0);
    check("rst_round_key", round_key, 128'h0);
    resetn = 1'b1;

    stream_check(FIPS_K10, -1);
    @(negedge clk); key_sel = 4'd0; #1;
    check("fips_k0", round_key, 128'h2b7e151628aed2a6abf7158809cf4f3c);
    @(negedge clk); key_sel = 4'd9; #1;
    check("fips_k9", round_key, 128'hac7766f319fadc2128d12941575c006e);
    @(negedge clk); key_sel = 4'd1; #1;
    check("fips_k1", round_key, 128'ha0fafe1788542cb123a339392a6c7605);

    stream_check(FIPS_K10, 5);
    stream_check(128'h0, -1);

    @(negedge clk);
    last_key = {$urandom, $urandom, $urandom, $urandom};
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    repeat (3) @(negedge clk);
    resetn   = 1'b0;
    key_sel  = 4'd10;
    #1;
    check("midrst_key_rdy", 128'(key_rdy), 128'h0);
    check("midrst_busy", 128'(busy), 128'h0);
    check("midrst_gen_valid", 128'(gen_valid), 128'h0);
    check("midrst_gen_key", gen_key, 128'h0);
    check("midrst_round_key", round_key, 128'h0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (12) @(negedge clk);
    check("post_rst_key_rdy", 128'(key_rdy), 128'h0);
    check("post_rst_busy", 128'(busy), 128'h0);

    for (int n = 0; n < 5; n++)
      stream_check({$urandom, $urandom, $urandom, $urandom},
                   (n == 3) ? int'($urandom_range(1, 10)) : -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
